// File: rtl/lcd_spi_writer_if.sv
// Write-side handshake between the LCD control mux and the SPI writer.
// The mux drives data/en_write; the writer reports its status back.
interface lcd_spi_writer_if;
  logic [8:0] data;
  logic       en_write;
  logic       ready;
  logic       busy;
  logic       wr_done;
  logic       overflow;

  modport master (
    output data,
    output en_write,
    input  ready,
    input  busy,
    input  wr_done,
    input  overflow
  );

  modport slave (
    input  data,
    input  en_write,
    output ready,
    output busy,
    output wr_done,
    output overflow
  );
endinterface

// File: rtl/lcd_spi_writer.sv
// 9-bit LCD word serialiser onto a 4-wire SPI bus (mode 0, MSB first).
// One-entry holding register absorbs the strobe while a word shifts out.
module lcd_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 8
) (
  input  logic            sys_clk_50MHz,
  input  logic            sys_rst,
  lcd_spi_writer_if.slave wr,
  output logic            lcd_cs,
  output logic            lcd_sclk,
  output logic            lcd_mosi,
  output logic            lcd_dc
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_e;

  localparam logic [CNT_W-1:0] HC_END = CNT_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [8:0]       hold_q, hold_d;
  logic             hv_q, hv_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             dc_q, dc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ready_q;
  logic             hc_end;
  logic             take;

  assign hc_end = (hc_q == HC_END);

  always_comb begin
    state_d = state_q;
    hc_d    = hc_end ? '0 : hc_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hc_d = '0;
        if (hv_q) begin
          take    = 1'b1;
          sh_d    = hold_q[7:0];
          dc_d    = hold_q[8];
          mosi_d  = hold_q[7];
          cs_d    = 1'b0;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (hc_end) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (hc_end) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = sh_q[6];
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        if (hc_end) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (hc_end) begin
          // a pending word keeps busy high across the IDLE cycle
          busy_d  = hv_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    hv_d   = hv_q;
    ovf_d  = ovf_q;
    if (wr.en_write) begin
      if (!hv_q || take) begin
        hold_d = wr.data;
        hv_d   = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (take) begin
      hv_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      hold_q  <= 9'd0;
      hv_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ready_q <= !hv_d;
    end
  end

  assign wr.ready    = ready_q;
  assign wr.busy     = busy_q;
  assign wr.wr_done  = done_q;
  assign wr.overflow = ovf_q;
  assign lcd_cs      = cs_q;
  assign lcd_sclk    = sclk_q;
  assign lcd_mosi    = mosi_q;
  assign lcd_dc      = dc_q;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: two instances (CLK_DIV 2 and 1) driven
// with directed and random words, checked against a cycle-count model.
module tb_lcd_spi_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_spi_writer_if if0();
  lcd_spi_writer_if if1();

  logic [1:0] cs, sclk, mosi, dc;

  lcd_spi_writer #(.CLK_DIV(2), .CNT_W(8)) u_dut0 (
    .sys_clk_50MHz(clk),
    .sys_rst      (rst),
    .wr           (if0.slave),
    .lcd_cs       (cs[0]),
    .lcd_sclk     (sclk[0]),
    .lcd_mosi     (mosi[0]),
    .lcd_dc       (dc[0])
  );

  lcd_spi_writer #(.CLK_DIV(1), .CNT_W(8)) u_dut1 (
    .sys_clk_50MHz(clk),
    .sys_rst      (rst),
    .wr           (if1.slave),
    .lcd_cs       (cs[1]),
    .lcd_sclk     (sclk[1]),
    .lcd_mosi     (mosi[1]),
    .lcd_dc       (dc[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int cdv(input int c);
    return (c == 0) ? 2 : 1;
  endfunction

  function automatic logic get_en(input int c);
    return (c == 0) ? if0.en_write : if1.en_write;
  endfunction

  function automatic logic [8:0] get_d(input int c);
    return (c == 0) ? if0.data : if1.data;
  endfunction

  // {ready, busy, wr_done, overflow}
  function automatic logic [3:0] st(input int c);
    if (c == 0)
      return {if0.ready, if0.busy, if0.wr_done, if0.overflow};
    return {if1.ready, if1.busy, if1.wr_done, if1.overflow};
  endfunction

  task automatic drive(input int c, input logic e, input logic [8:0] d);
    if (c == 0) begin
      if0.en_write = e;
      if0.data     = d;
    end else begin
      if1.en_write = e;
      if1.data     = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word is taken from the buffer no earlier than
  // 18*CD+1 cycles after the previous take; CS falls at the take edge.
  int         cyc = 0;
  bit         started = 1'b0;
  logic       bv [2];
  logic [8:0] hw [2];
  int         nt [2];
  int         lt [2];
  logic       busy_m [2];
  logic       done_m [2];
  logic       ovf_m [2];
  logic [8:0] exp_w [2];
  int         exp_t [2];
  int         taken [2] = '{0, 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) started <= 1'b1;
    for (int c = 0; c < 2; c++) begin
      automatic int         cn = cyc + 1;
      automatic int         cd = cdv(c);
      automatic logic       e  = get_en(c);
      automatic logic [8:0] d  = get_d(c);
      automatic logic       tk;
      if (rst) begin
        bv[c]     <= 1'b0;
        nt[c]     <= 0;
        lt[c]     <= -1000;
        busy_m[c] <= 1'b0;
        done_m[c] <= 1'b0;
        ovf_m[c]  <= 1'b0;
      end else begin
        tk = bv[c] && (cn >= nt[c]);
        done_m[c] <= (cn == lt[c] + 17 * cd);
        if (tk) begin
          exp_w[c]  <= hw[c];
          exp_t[c]  <= cn;
          nt[c]     <= cn + 18 * cd + 1;
          lt[c]     <= cn;
          busy_m[c] <= 1'b1;
          taken[c]  <= taken[c] + 1;
        end else if (cn == nt[c] - 1) begin
          busy_m[c] <= bv[c];
        end
        if (e) begin
          if (!bv[c] || tk) begin
            hw[c] <= d;
            bv[c] <= 1'b1;
          end else begin
            ovf_m[c] <= 1'b1;
          end
        end else if (tk) begin
          bv[c] <= 1'b0;
        end
      end
    end
  end

  // Bus monitor: reconstructs each CS-low window and checks it.
  logic       pcs [2];
  logic       psclk [2];
  bit         inw [2];
  int         fall [2];
  int         nr [2];
  logic [7:0] bits [2];
  logic       dc0 [2];
  int         done_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < 2; c++) begin
        automatic logic       ccs = cs[c];
        automatic logic       csk = sclk[c];
        automatic logic       cmo = mosi[c];
        automatic logic       cdc = dc[c];
        automatic int         cd  = cdv(c);
        automatic logic [3:0] s   = st(c);
        if (rst) begin
          inw[c]      <= 1'b0;
          done_cnt[c] <= taken[c];
        end else begin
          chk($sformatf("ch%0d_ready", c), s[3], !bv[c]);
          chk($sformatf("ch%0d_busy", c), s[2], busy_m[c]);
          chk($sformatf("ch%0d_wr_done", c), s[1], done_m[c]);
          chk($sformatf("ch%0d_overflow", c), s[0], ovf_m[c]);
          if (ccs) chk($sformatf("ch%0d_sclk_idle", c), csk, 1'b0);
          if (pcs[c] && !ccs) begin
            chk($sformatf("ch%0d_cs_fall_t", c), cyc, exp_t[c]);
            chk($sformatf("ch%0d_dc", c), cdc, exp_w[c][8]);
            inw[c]  <= 1'b1;
            fall[c] <= cyc;
            nr[c]   <= 0;
            bits[c] <= 8'd0;
            dc0[c]  <= cdc;
          end else if (inw[c] && !ccs) begin
            chk($sformatf("ch%0d_dc_stable", c), cdc, dc0[c]);
            if (!psclk[c] && csk) begin
              chk($sformatf("ch%0d_rise_t", c), cyc - fall[c],
                  (2 * nr[c] + 1) * cd);
              bits[c] <= {bits[c][6:0], cmo};
              nr[c]   <= nr[c] + 1;
            end
          end else if (inw[c] && ccs) begin
            chk($sformatf("ch%0d_cs_len", c), cyc - fall[c], 17 * cd);
            chk($sformatf("ch%0d_nrise", c), nr[c], 8);
            chk($sformatf("ch%0d_byte", c), bits[c], exp_w[c][7:0]);
            done_cnt[c] <= done_cnt[c] + 1;
            inw[c]      <= 1'b0;
          end
        end
        pcs[c]   <= ccs;
        psclk[c] <= csk;
      end
    end
  end

  initial begin
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    drive(0, 1'b1, 9'h02A);
    drive(1, 1'b1, 9'h0FF);
    tick();
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    repeat (60) tick();

    drive(0, 1'b1, 9'h1A5);
    tick();
    drive(0, 1'b0, 9'h000);
    repeat (50) tick();

    drive(0, 1'b1, 9'h036);
    tick();
    drive(0, 1'b0, 9'h000);
    tick();
    drive(0, 1'b1, 9'h100);
    tick();
    drive(0, 1'b0, 9'h000);
    repeat (90) tick();
    chk("b2b_overflow", if0.overflow, 1'b0);
    chk("b2b_words", done_cnt[0], taken[0]);

    drive(0, 1'b1, 9'h0C3);
    tick();
    drive(0, 1'b0, 9'h000);
    repeat (15) tick();
    chk("pre_rst_cs", cs[0], 1'b0);
    chk("pre_rst_sclk", sclk[0], 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_cs", cs[0], 1'b1);
    chk("rst_sclk", sclk[0], 1'b0);
    chk("rst_mosi", mosi[0], 1'b0);
    chk("rst_dc", dc[0], 1'b0);
    chk("rst_status", st(0), 4'b1000);
    rst = 1'b0;
    drive(0, 1'b1, 9'h05A);
    tick();
    drive(0, 1'b0, 9'h000);
    repeat (50) tick();

    drive(0, 1'b1, 9'h011);
    tick();
    drive(0, 1'b1, 9'h122);
    tick();
    drive(0, 1'b1, 9'h033);
    tick();
    drive(0, 1'b0, 9'h000);
    repeat (90) tick();
    chk("ovf_set", if0.overflow, 1'b1);
    repeat (40) tick();
    chk("ovf_sticky", if0.overflow, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (2500) begin
      for (int c = 0; c < 2; c++)
        drive(c, $urandom_range(0, 5) == 0, 9'($urandom));
      tick();
    end
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    repeat (100) tick();
    for (int c = 0; c < 2; c++)
      chk($sformatf("ch%0d_drain", c), done_cnt[c], taken[c]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_spi_writer.md
Name: lcd_spi_writer

Overview:
Serialises the 9-bit LCD write words produced by the LCD control mux (init/picture data plus en_write strobe) onto the panel's 4-wire SPI bus (CS, SCLK, MOSI, DC). Bit 8 of each word is the D/C flag (0 = command, 1 = data) and bits 7:0 are the payload, sent MSB first in SPI mode 0. A one-entry holding register decouples the single-cycle en_write strobe from the multi-cycle serial transfer. Back-pressure is reported through ready, and lost words are reported through overflow.

Parameters:
CLK_DIV, 2, SCLK half-period in sys_clk_50MHz cycles (>=1); 2 gives 12.5 MHz SCLK.
CNT_W, 8, width of the half-period counter; must hold CLK_DIV-1.

Ports:
sys_clk_50MHz  input  1  system clock; single clock domain; all logic on rising edge.
sys_rst  input  1  synchronous, active-high reset.
data  input  9  write word: [8] = D/C, [7:0] = byte.
en_write  input  1  one-cycle strobe; data valid in the same cycle.
ready  output  1  holding register empty; an en_write now is guaranteed accepted.
busy  output  1  serial engine active (CS low or in inter-word gap).
wr_done  output  1  one-cycle pulse, coincident with CS returning high after a word.
overflow  output  1  sticky; set when a word is dropped; cleared only by reset.
lcd_cs  output  1  chip select, active low.
lcd_sclk  output  1  serial clock, idles low.
lcd_mosi  output  1  serial data; changes on SCLK falling edge or while CS is high.
lcd_dc  output  1  D/C line; held stable for the whole word while CS is low.

Behaviour:
- Reset values, applied on any edge with sys_rst=1 (mid-transfer included; the word in flight and the held word are discarded):
  - lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0.
  - ready=1, busy=0, wr_done=0, overflow=0.
  - FSM enters IDLE; counters and holding register are cleared.
- All outputs are registered.
- Holding register (buf, buf_valid):
  - en_write with buf_valid=0 stores data and sets buf_valid.
  - ready = !buf_valid.
  - en_write with buf_valid=1 in the same cycle the FSM takes buf: accepted; buf is reloaded and buf_valid stays 1.
  - en_write with buf_valid=1 and no take: word dropped; overflow <= 1.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP. The half-period counter hc counts 0..CLK_DIV-1; each state lasts CLK_DIV cycles except IDLE.
  - IDLE: if buf_valid, take buf into shreg, then lcd_dc<=buf[8], lcd_mosi<=buf[7], lcd_cs<=0, bit_cnt<=0, busy<=1 -> LOW. Otherwise hold idle values.
  - LOW (SCLK=0): at end of half-period, lcd_sclk<=1 -> HIGH.
  - HIGH (SCLK=1; panel samples on the rising edge): at end of half-period, lcd_sclk<=0.
    - If bit_cnt==7 -> HOLD.
    - Else bit_cnt+1, lcd_mosi<=next bit -> LOW.
  - HOLD: at end, lcd_cs<=1, wr_done<=1 for one cycle, lcd_mosi<=0 -> GAP.
  - GAP: CS stays high for CLK_DIV cycles, then -> IDLE with busy<=0. If buf_valid, busy stays 1 and the next word starts.
- Timing for CLK_DIV=2:
  - en_write at edge E -> buf_valid at E+1 -> lcd_cs low after E+2 (latency 2).
  - 8 SCLK rising edges, at CS-fall + (2k+1)*CLK_DIV, k=0..7.
  - CS high at CS-fall + 17*CLK_DIV (34 cycles).
  - Minimum word-to-word CS-fall spacing: 18*CLK_DIV + 1 cycles (37), due to the IDLE cycle.
- lcd_dc never changes while lcd_cs=0.

Test Plan:
- Single command: data=9'h02A, en_write one cycle, CLK_DIV=2 -> CS low 2 cycles later; DC=0; MOSI bits sampled on 8 SCLK rises = 0,0,1,0,1,0,1,0; CS high 34 cycles after falling; one wr_done pulse.
- Data word: data=9'h1A5 -> DC=1 throughout; bits 1,0,1,0,0,1,0,1; SCLK low whenever CS is high.
- Back-to-back: 9'h036 then 9'h100 two cycles apart -> both accepted (ready drops after the first, recovers when IDLE takes it); CS-fall spacing 37 cycles; 2 wr_done pulses; overflow=0.
- Overflow: three en_write on consecutive cycles while idle -> words 1 and 2 sent; word 3 dropped; overflow=1 and stays 1.
- Reset mid-word: assert sys_rst after the 4th SCLK rise -> next edge gives CS=1, SCLK=0, ready=1, busy=0, no wr_done; a new word then transfers normally.
- CLK_DIV=1: word 9'h0FF -> CS low 17 cycles; 8 SCLK rises 2 cycles apart; all MOSI bits 1.
